// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;

  localparam int FLG_EMPTY = 0;
  localparam int FLG_FULL  = 1;
  localparam int FLG_AE    = 2;
  localparam int FLG_AF    = 3;
  localparam int FLG_W     = 4;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit more than the pointers.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one write port, one registered read port.
module fifo_mem #(
  parameter int DATA_W = 32,
  parameter int AW     = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with programmable almost-empty/almost-full thresholds,
// sticky overflow/underflow flags and a synchronous flush.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wen,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ren,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [AW:0]       level,
  input  logic [AW:0]       ae_thresh,
  input  logic [AW:0]       af_thresh,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow
);

  localparam int          LW      = level_w(DEPTH);
  localparam logic [AW:0] DEPTH_L = LW'(DEPTH);
  localparam logic [AW:0] ONE_L   = LW'(1);

  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              wa;
  logic              ra;
  logic              rd_seen;
  logic [DATA_W-1:0] mem_rdata;
  logic [FLG_W-1:0]  flg;

  assign flg[FLG_EMPTY] = (level == '0);
  assign flg[FLG_FULL]  = (level == DEPTH_L);
  assign flg[FLG_AE]    = (level <= ae_thresh);
  assign flg[FLG_AF]    = (level >= af_thresh);

  assign empty        = flg[FLG_EMPTY];
  assign full         = flg[FLG_FULL];
  assign almost_empty = flg[FLG_AE];
  assign almost_full  = flg[FLG_AF];

  // Fullness/emptiness are judged on the pre-edge level: no write-through, no fall-through.
  assign wa = wen & ~full  & ~flush;
  assign ra = ren & ~empty & ~flush;

  fifo_mem #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wa),
    .waddr (wptr),
    .wdata (wdata),
    .re    (ra),
    .raddr (rptr),
    .rdata (mem_rdata)
  );

  // The array has no reset, so rdata reads as zero until the first accepted read.
  assign rdata = rd_seen ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      rvalid    <= 1'b0;
      rd_seen   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      rvalid    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rvalid    <= ra;
      overflow  <= overflow  | (wen & full);
      underflow <= underflow | (ren & empty);
      if (ra) rd_seen <= 1'b1;
      if (wa) wptr <= wptr + 1'b1;
      if (ra) rptr <= rptr + 1'b1;
      case ({wa, ra})
        2'b10:   level <= level + ONE_L;
        2'b01:   level <= level - ONE_L;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags (DEPTH=8, DATA_W=8) with a read-data scoreboard.
module tb_sync_fifo_flags;

  localparam int DW = 8;
  localparam int DP = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wen = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          ren = 1'b0;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic [AW:0]   level;
  logic [AW:0]   ae_thresh = 4'd2;
  logic [AW:0]   af_thresh = 4'd6;
  logic          empty, full, almost_empty, almost_full, overflow, underflow;

  sync_fifo_flags #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wen          (wen),
    .wdata        (wdata),
    .ren          (ren),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .level        (level),
    .ae_thresh    (ae_thresh),
    .af_thresh    (af_thresh),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  int            mlevel = 0;
  logic          movf = 1'b0;
  logic          munf = 1'b0;
  logic          exp_rvalid = 1'b0;
  logic [DW-1:0] last_rd = '0;
  logic          checking = 1'b0;

  // Scoreboard: every rvalid must deliver the next expected word.
  always @(negedge clk) begin
    if (checking && !rst) begin
      tests_run++;
      if (rvalid !== exp_rvalid) begin
        tests_failed++;
        $display("FAIL rvalid: got %0b expected %0b at %0t", rvalid, exp_rvalid, $time);
      end
      if (rvalid === 1'b1) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL rdata_unexpected: got %02h with no expected word", rdata);
        end else begin
          automatic logic [DW-1:0] e = exp_q.pop_front();
          if (rdata !== e) begin
            tests_failed++;
            $display("FAIL rdata: got %02h expected %02h at %0t", rdata, e, $time);
          end
        end
      end
    end
  end

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    logic wa_m, ra_m;
    wen = w; wdata = d; ren = r; flush = f;
    wa_m = w && (mlevel != DP) && !f;
    ra_m = r && (mlevel != 0) && !f;
    @(posedge clk);
    #1;
    if (f) begin
      mq.delete();
      mlevel = 0; movf = 1'b0; munf = 1'b0; exp_rvalid = 1'b0;
    end else begin
      if (ra_m) begin
        last_rd = mq.pop_front();
        exp_q.push_back(last_rd);
      end
      if (wa_m) mq.push_back(d);
      mlevel = mlevel + int'(wa_m) - int'(ra_m);
      movf = movf | (w && (mlevel - int'(wa_m) + int'(ra_m) == DP));
      munf = munf | (r && (mlevel - int'(wa_m) + int'(ra_m) == 0));
      exp_rvalid = ra_m;
    end
    wen = 1'b0; ren = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests_run++; if (level !== 4'd0)    begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", level); end
    tests_run++; if (empty !== 1'b1)    begin tests_failed++; $display("FAIL reset_empty: got %0b expected 1", empty); end
    tests_run++; if (full !== 1'b0)     begin tests_failed++; $display("FAIL reset_full: got %0b expected 0", full); end
    tests_run++; if (almost_empty !== 1'b1) begin tests_failed++; $display("FAIL reset_ae: got %0b expected 1", almost_empty); end
    tests_run++; if (almost_full !== 1'b0)  begin tests_failed++; $display("FAIL reset_af: got %0b expected 0", almost_full); end
    tests_run++; if (rvalid !== 1'b0)   begin tests_failed++; $display("FAIL reset_rvalid: got %0b expected 0", rvalid); end
    tests_run++; if (rdata !== 8'h00)   begin tests_failed++; $display("FAIL reset_rdata: got %02h expected 00", rdata); end
    tests_run++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      tests_failed++; $display("FAIL reset_sticky: got ovf=%0b unf=%0b expected 0/0", overflow, underflow);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    checking = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < DP; i++) step(1'b1, 8'h11 + DW'(i), 1'b0, 1'b0);
    tests_run++; if (full !== 1'b1 || level !== 4'd8) begin
      tests_failed++; $display("FAIL basic_full: got full=%0b level=%0d expected 1/8", full, level);
    end
    for (int i = 0; i < DP; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    tests_run++; if (empty !== 1'b1 || level !== 4'd0) begin
      tests_failed++; $display("FAIL basic_empty: got empty=%0b level=%0d expected 1/0", empty, level);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DP; i++) step(1'b1, 8'h21 + DW'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    tests_run++; if (level !== 4'(mlevel) || level !== 4'd7) begin
      tests_failed++; $display("FAIL ovf_level: got %0d expected 7", level);
    end
    tests_run++; if (overflow !== 1'b1) begin
      tests_failed++; $display("FAIL ovf_flag: got %0b expected 1", overflow);
    end
    for (int i = 0; i < DP; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    tests_run++; if (underflow !== munf || munf !== 1'b1) begin
      tests_failed++; $display("FAIL ovf_underflow_after_drain: got %0b expected 1", underflow);
    end
  endtask

  task automatic test_underflow();
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 8'h5C, 1'b1, 1'b0);
    tests_run++; if (level !== 4'd1 || underflow !== 1'b1 || rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL unf_simul: got level=%0d unf=%0b rvalid=%0b expected 1/1/0", level, underflow, rvalid);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    tests_run++; if (rvalid !== 1'b1 || rdata !== 8'h5C) begin
      tests_failed++; $display("FAIL unf_readback: got rvalid=%0b rdata=%02h expected 1/5c", rvalid, rdata);
    end
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_thresholds();
    step(1'b0, '0, 1'b0, 1'b1);
    ae_thresh = 4'd2; af_thresh = 4'd6;
    for (int l = 0; l <= DP; l++) begin
      #1;
      tests_run++;
      if (almost_empty !== (l <= 2) || almost_full !== (l >= 6) || level !== 4'(l)) begin
        tests_failed++;
        $display("FAIL thresh_l%0d: got level=%0d ae=%0b af=%0b expected ae=%0b af=%0b",
                 l, level, almost_empty, almost_full, l <= 2, l >= 6);
      end
      if (l < DP) step(1'b1, DW'(8'hC0 + l), 1'b0, 1'b0);
    end
    af_thresh = 4'd9; #1;
    tests_run++; if (almost_full !== 1'b0) begin
      tests_failed++; $display("FAIL thresh_af_above_depth: got %0b expected 0", almost_full);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    af_thresh = 4'd0; #1;
    tests_run++; if (almost_full !== 1'b1 || almost_empty !== 1'b1) begin
      tests_failed++; $display("FAIL thresh_af0: got af=%0b ae=%0b expected 1/1", almost_full, almost_empty);
    end
    af_thresh = 4'd6;
  endtask

  task automatic test_stream();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3 * DP + 3; i++) begin
      step(1'b1, DW'(i + 1), i >= 3, 1'b0);
      tests_run++;
      if (level !== 4'((i < 3) ? i + 1 : 3)) begin
        tests_failed++; $display("FAIL stream_level_%0d: got %0d expected %0d", i, level, (i < 3) ? i + 1 : 3);
      end
    end
    tests_run++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      tests_failed++; $display("FAIL stream_sticky: got ovf=%0b unf=%0b expected 0/0", overflow, underflow);
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_flush_reset();
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < DP; i++) step(1'b1, 8'h40 + DW'(i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    tests_run++; if (level !== 4'd5 || overflow !== 1'b1 || underflow !== 1'b1) begin
      tests_failed++; $display("FAIL flush_setup: got level=%0d ovf=%0b unf=%0b expected 5/1/1", level, overflow, underflow);
    end
    step(1'b1, 8'h99, 1'b0, 1'b1);
    tests_run++; if (level !== 4'd0 || overflow !== 1'b0 || underflow !== 1'b0 || rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_clear: got level=%0d ovf=%0b unf=%0b rvalid=%0b expected 0/0/0/0", level, overflow, underflow, rvalid);
    end
    tests_run++; if (rdata !== last_rd || last_rd !== 8'h42) begin
      tests_failed++; $display("FAIL flush_rdata_hold: got %02h expected 42", rdata);
    end
    step(1'b1, 8'h71, 1'b0, 1'b0);
    step(1'b1, 8'h72, 1'b1, 1'b0);
    step(1'b1, 8'h73, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    tests_run++; if (level !== 4'd0 || rvalid !== 1'b0 || rdata !== 8'h00 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_reset: got level=%0d rvalid=%0b rdata=%02h empty=%0b expected 0/0/00/1", level, rvalid, rdata, empty);
    end
    mq.delete(); exp_q.delete();
    mlevel = 0; movf = 1'b0; munf = 1'b0; exp_rvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, 8'h81, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    tests_run++; if (exp_q.size() != 0 || level !== 4'd0) begin
      tests_failed++; $display("FAIL post_reset_drain: got pending=%0d level=%0d expected 0/0", exp_q.size(), level);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_thresholds();
    test_stream();
    test_flush_reset();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Parametrised synchronous FIFO with a fully specified behavioural model.
- It generalises the FIFO mode of the RAM blackbox: any data width, any power-of-two depth, programmable almost-empty/almost-full thresholds, sticky overflow/underflow flags and a synchronous flush.
- Used in fabric-level designs and as the simulation reference for FIFO-mode RAM inference.
- Single clock domain; read and write share clk.

Parameters:
- DATA_W, 32, width of wdata/rdata in bits (1..64).
- DEPTH, 512, number of entries; power of two, at least 4.
- AW, $clog2(DEPTH), derived pointer width; never overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of pointers, level and sticky flags.
- wen  in  1  write request.
- wdata  in  DATA_W  write data.
- ren  in  1  read request.
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  rdata was updated at the last edge.
- level  out  AW+1  current occupancy, 0..DEPTH.
- ae_thresh  in  AW+1  almost-empty threshold.
- af_thresh  in  AW+1  almost-full threshold.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- almost_empty  out  1  level <= ae_thresh.
- almost_full  out  1  level >= af_thresh.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: wptr=0, rptr=0, level=0, rdata=0, rvalid=0, overflow=0, underflow=0. Consequently empty=1, full=0, almost_empty=1. almost_full follows its formula, so it is 1 only when af_thresh==0. Storage array is not reset.
- Status outputs (empty, full, almost_*) are combinational from the registered level and the threshold inputs. level, overflow and underflow are registered.
- Write acceptance: wa = wen & ~full & ~flush. On wa, mem[wptr] <= wdata and wptr increments modulo DEPTH.
- Read acceptance: ra = ren & ~empty & ~flush. On ra, rdata <= mem[rptr] and rptr increments modulo DEPTH.
- Read latency: 1 cycle. rvalid <= ra, so rvalid is high exactly for the cycle after each accepted read. rdata holds its value when there is no accepted read.
- Level update: level <= level + wa - ra. A simultaneous accepted read and write leaves level unchanged.
- Full with wen and ren both high: the read is accepted, the write is rejected and overflow is set. Fullness is judged on the pre-edge level; there is no write-through when full.
- Empty with wen and ren both high: the write is accepted, the read is rejected and underflow is set. There is no fall-through; the written data is readable from the next cycle.
- Pointer wrap: after DEPTH accepted writes wptr returns to 0. Ordering stays strict FIFO across the wrap.
- Sticky flags: overflow <= overflow | (wen & full & ~flush); underflow <= underflow | (ren & empty & ~flush). They clear only on rst or flush.
- flush (synchronous, highest priority after rst): pointers, level, overflow, underflow and rvalid go to 0. wen and ren in the same cycle are ignored. rdata holds. Storage contents are untouched but unreachable.
- Reset mid-operation: everything returns to reset values immediately. Any in-flight read is lost (rvalid=0).
- Threshold range: values above DEPTH are legal. almost_empty is then always 1, and almost_full is always 0 when af_thresh > DEPTH. Thresholds may change on any cycle; the flags follow combinationally.

Decomposition:
- Package sync_fifo_pkg holds:
  - the level-width helper function (AW+1 from DEPTH);
  - the flag-vector index constants FLG_EMPTY=0, FLG_FULL=1, FLG_AE=2, FLG_AF=3, for packing a 4-bit FFLAGS-style view.
- Sub-module fifo_mem: simple dual-port register array with one write port and one registered read port (clk only, no reset).
- Top level holds the pointers, level counter, acceptance logic and flags.

Test Plan:
- Basic order: DEPTH=8, DATA_W=8. After reset, write 0x11..0x18 on consecutive cycles -> full=1, level=8. Then read 8 times -> rdata sequence 0x11..0x18, each value one cycle after ren, rvalid pulses each cycle, then empty=1.
- Overflow/simultaneous: from full, hold wen=ren=1 for 1 cycle with wdata=0xAA -> level stays 7, overflow=1. 0xAA never appears in 8 subsequent reads.
- Underflow/empty: from empty, assert wen=ren=1 with wdata=0x5C -> level=1, underflow=1, rvalid=0. Next cycle ren=1 -> rdata=0x5C with rvalid=1.
- Thresholds: ae_thresh=2, af_thresh=6. Step level 0..8 -> almost_empty=1 exactly at levels 0..2, almost_full=1 exactly at levels 6..8. Set af_thresh=0 -> almost_full=1 at level 0.
- Wrap and steady stream: run 3*DEPTH+3 cycles of continuous write with reads starting after 3 cycles, incrementing data -> level constant at 3, no data loss or reordering across pointer wrap, no sticky flags.
- Flush/reset: at level 5 with sticky flags set, pulse flush with wen=1 -> level=0, flags 0, rdata unchanged. Then assert rst asynchronously mid-stream between edges -> outputs take their reset values immediately, before the next clk edge.
